seven_seg_scan_decoder: RTL and testbench



---
 rtl/seven_seg_scan_decoder.sv | 181 ++++++++++++++++++
 tb/tb_seven_seg_scan_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_decoder.sv
// Recovers digit codes and binary value from an active-low multiplexed 7-segment scan bus.
// Pulse 6 cycles after the frame-completing capture; no backpressure, the scan bus is sampled continuously.
module seven_seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 524288
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [15:0] game_time,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stale
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {COLLECT, CONVERT, PUBLISH} state_t;

    logic [6:0]    seg_q;
    logic [3:0]    an_q, an_prev_q;
    logic [7:0]    dwell_q, dwell_d;
    logic [15:0]   slots_q, slots_d;
    logic [3:0]    seen_q, seen_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          stale_q, stale_d;

    state_t        state_q;
    logic [15:0]   conv_q, acc_q, acc_next;
    logic [1:0]    step_q;
    logic [15:0]   digits_q, game_time_q;
    logic          frame_valid_q, frame_err_q;

    logic          an_valid, stable, capture, snapshot, timeout, has_err;
    logic [1:0]    an_idx;
    logic [3:0]    code, cur_digit, cur_val;

    function automatic logic [3:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = 4'd0;
            7'b1001111: decode = 4'd1;
            7'b0010010: decode = 4'd2;
            7'b0000110: decode = 4'd3;
            7'b1001100: decode = 4'd4;
            7'b0100100: decode = 4'd5;
            7'b0100000: decode = 4'd6;
            7'b0001111: decode = 4'd7;
            7'b0000000: decode = 4'd8;
            7'b0000100: decode = 4'd9;
            7'b1111111: decode = 4'd10;
            default:    decode = 4'd15;
        endcase
    endfunction

    always_comb begin
        an_valid = 1'b1;
        an_idx   = 2'd0;
        case (an_q)
            4'b1110: an_idx = 2'd0;
            4'b1101: an_idx = 2'd1;
            4'b1011: an_idx = 2'd2;
            4'b0111: an_idx = 2'd3;
            default: an_valid = 1'b0;
        endcase
    end

    assign code     = decode(seg_q);
    assign stable   = an_valid && (an_q == an_prev_q);
    assign capture  = stable && (dwell_q == 8'(SETTLE_CYCLES - 1));
    assign snapshot = (state_q == COLLECT) && (seen_q == 4'hF);
    assign timeout  = !capture && (idle_q == IW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        dwell_d = 8'd0;
        if (stable)
            dwell_d = (dwell_q == 8'(SETTLE_CYCLES)) ? dwell_q : dwell_q + 8'd1;

        slots_d = slots_q;
        seen_d  = seen_q;
        if (snapshot || timeout)
            seen_d = 4'h0;
        // A capture landing on the snapshot cycle belongs to the next frame.
        if (capture) begin
            slots_d[{an_idx, 2'b00} +: 4] = code;
            seen_d[an_idx]                = 1'b1;
        end

        idle_d  = idle_q;
        stale_d = stale_q;
        if (capture) begin
            idle_d  = '0;
            stale_d = 1'b0;
        end else begin
            if (idle_q != IW'(TIMEOUT_CYCLES))
                idle_d = idle_q + IW'(1);
            if (timeout)
                stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q     <= '0;
            an_q      <= '0;
            an_prev_q <= '0;
            dwell_q   <= '0;
            slots_q   <= '0;
            seen_q    <= '0;
            idle_q    <= '0;
            stale_q   <= 1'b0;
        end else begin
            seg_q     <= seg;
            an_q      <= an;
            an_prev_q <= an_q;
            dwell_q   <= dwell_d;
            slots_q   <= slots_d;
            seen_q    <= seen_d;
            idle_q    <= idle_d;
            stale_q   <= stale_d;
        end
    end

    // Thousands first: step 0 selects nibble 3, i.e. the inverted step index.
    assign cur_digit = conv_q[{~step_q, 2'b00} +: 4];
    assign cur_val   = (cur_digit == 4'd10) ? 4'd0 : cur_digit;
    assign acc_next  = (acc_q << 3) + (acc_q << 1) + {12'd0, cur_val};
    assign has_err   = (conv_q[15:12] == 4'hF) || (conv_q[11:8] == 4'hF) ||
                       (conv_q[7:4]   == 4'hF) || (conv_q[3:0]  == 4'hF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= COLLECT;
            conv_q        <= '0;
            acc_q         <= '0;
            step_q        <= '0;
            digits_q      <= '0;
            game_time_q   <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            case (state_q)
                COLLECT: begin
                    if (snapshot) begin
                        conv_q  <= slots_q;
                        acc_q   <= '0;
                        step_q  <= '0;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    acc_q  <= acc_next;
                    step_q <= step_q + 2'd1;
                    // Outputs load on the last step so the pulse coincides with PUBLISH.
                    if (step_q == 2'd3) begin
                        state_q <= PUBLISH;
                        if (!has_err) begin
                            digits_q      <= conv_q;
                            game_time_q   <= acc_next;
                            frame_valid_q <= 1'b1;
                        end else begin
                            frame_err_q   <= 1'b1;
                        end
                    end
                end
                PUBLISH: state_q <= COLLECT;
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign digits      = digits_q;
    assign game_time   = game_time_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: scans driven as seg/an hold periods, pulses tallied on negedge.
module tb_seven_seg_scan_decoder;

    localparam int SETTLE = 4;
    localparam int TMO    = 64;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  seg   = 7'h7F;
    logic [3:0]  an    = 4'hF;
    logic [15:0] digits, game_time;
    logic        frame_valid, frame_err, stale;

    seven_seg_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg        (seg),
        .an         (an),
        .digits     (digits),
        .game_time  (game_time),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int fv_cyc = 0;
    logic [15:0] gt_log [0:63];

    always @(negedge clk) begin
        if (frame_valid) begin
            gt_log[fv_cnt[5:0]] = game_time;
            fv_cnt = fv_cnt + 1;
            fv_cyc = cyc;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
    end

    function automatic logic [6:0] pat(input int d);
        case (d)
            0:  pat = 7'b0000001;
            1:  pat = 7'b1001111;
            2:  pat = 7'b0010010;
            3:  pat = 7'b0000110;
            4:  pat = 7'b1001100;
            5:  pat = 7'b0100100;
            6:  pat = 7'b0100000;
            7:  pat = 7'b0001111;
            8:  pat = 7'b0000000;
            9:  pat = 7'b0000100;
            10: pat = 7'b1111111;
            default: pat = 7'b1111110;
        endcase
    endfunction

    task automatic hold(input logic [6:0] s, input logic [3:0] a, input int n);
        seg = s;
        an  = a;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Ones first, thousands last; c_last is the cycle count when the thousands hold begins.
    task automatic scan(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1,
                        input logic [6:0] p0, input int dwell, output int c_last);
        hold(p0, 4'b1110, dwell);
        hold(p1, 4'b1101, dwell);
        hold(p2, 4'b1011, dwell);
        c_last = cyc;
        hold(p3, 4'b0111, dwell);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (digits !== 16'h0)    begin errors++; $display("FAIL reset_digits: got %h expected %h", digits, 16'h0); end
        checks++; if (game_time !== 16'h0) begin errors++; $display("FAIL reset_game_time: got %h expected %h", game_time, 16'h0); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
        checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (stale !== 1'b0)      begin errors++; $display("FAIL reset_stale: got %b expected 0", stale); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_scan_1234;
        int c_last;
        int fv0;
        fv0 = fv_cnt;
        scan(pat(1), pat(2), pat(3), pat(4), 16, c_last);
        scan(pat(1), pat(2), pat(3), pat(4), 16, c_last);
        wait_cycles(12);
        checks++; if (fv_cnt !== fv0 + 2)      begin errors++; $display("FAIL scan1234_pulses: got %0d expected %0d", fv_cnt - fv0, 2); end
        checks++; if (digits !== 16'h1234)     begin errors++; $display("FAIL scan1234_digits: got %h expected %h", digits, 16'h1234); end
        checks++; if (game_time !== 16'd1234)  begin errors++; $display("FAIL scan1234_game_time: got %0d expected %0d", game_time, 1234); end
        checks++; if (fe_cnt !== 0)            begin errors++; $display("FAIL scan1234_err_pulses: got %0d expected 0", fe_cnt); end
        checks++; if (fv_cyc !== c_last + 11)  begin errors++; $display("FAIL scan1234_latency: got %0d expected %0d", fv_cyc, c_last + 11); end
        checks++; if (stale !== 1'b0)          begin errors++; $display("FAIL scan1234_stale: got %b expected 0", stale); end
    endtask

    task automatic test_blank;
        int c_last;
        int fv0;
        fv0 = fv_cnt;
        scan(pat(10), pat(5), pat(6), pat(7), 16, c_last);
        wait_cycles(12);
        checks++; if (fv_cnt !== fv0 + 1)     begin errors++; $display("FAIL blank_pulses: got %0d expected 1", fv_cnt - fv0); end
        checks++; if (digits !== 16'hA567)    begin errors++; $display("FAIL blank_digits: got %h expected %h", digits, 16'hA567); end
        checks++; if (game_time !== 16'd567)  begin errors++; $display("FAIL blank_game_time: got %0d expected %0d", game_time, 567); end
    endtask

    task automatic test_invalid;
        int c_last;
        int fv0;
        int fe0;
        scan(pat(0), pat(0), pat(4), pat(2), 16, c_last);
        wait_cycles(12);
        checks++; if (game_time !== 16'd42)   begin errors++; $display("FAIL pre42_game_time: got %0d expected %0d", game_time, 42); end
        checks++; if (digits !== 16'h0042)    begin errors++; $display("FAIL pre42_digits: got %h expected %h", digits, 16'h0042); end
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        scan(pat(0), pat(0), pat(4), 7'b0110110, 16, c_last);
        wait_cycles(12);
        checks++; if (fe_cnt !== fe0 + 1)     begin errors++; $display("FAIL invalid_err_pulses: got %0d expected 1", fe_cnt - fe0); end
        checks++; if (fv_cnt !== fv0)         begin errors++; $display("FAIL invalid_valid_pulses: got %0d expected 0", fv_cnt - fv0); end
        checks++; if (game_time !== 16'd42)   begin errors++; $display("FAIL invalid_game_time: got %0d expected %0d", game_time, 42); end
        checks++; if (digits !== 16'h0042)    begin errors++; $display("FAIL invalid_digits: got %h expected %h", digits, 16'h0042); end
    endtask

    task automatic test_toggle_stale;
        int c_last;
        int fv0;
        int fe0;
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL toggle_stale_start: got %b expected 0", stale); end
        for (int i = 0; i < 20; i++) begin
            hold(pat(1), 4'b1110, 2);
            hold(pat(1), 4'b1101, 2);
        end
        checks++; if (fv_cnt !== fv0) begin errors++; $display("FAIL toggle_valid_pulses: got %0d expected 0", fv_cnt - fv0); end
        checks++; if (fe_cnt !== fe0) begin errors++; $display("FAIL toggle_err_pulses: got %0d expected 0", fe_cnt - fe0); end
        checks++; if (stale !== 1'b1) begin errors++; $display("FAIL toggle_stale_raised: got %b expected 1", stale); end
        checks++; if (game_time !== 16'd42) begin errors++; $display("FAIL toggle_game_time_kept: got %0d expected %0d", game_time, 42); end
        scan(pat(1), pat(2), pat(3), pat(4), 16, c_last);
        wait_cycles(12);
        checks++; if (stale !== 1'b0)     begin errors++; $display("FAIL toggle_stale_cleared: got %b expected 0", stale); end
        checks++; if (fv_cnt !== fv0 + 1) begin errors++; $display("FAIL toggle_recover_pulses: got %0d expected 1", fv_cnt - fv0); end
    endtask

    task automatic test_reset_mid;
        int c_last;
        int fv0;
        int fe0;
        fv0 = fv_cnt;
        fe0 = fe_cnt;
        hold(pat(5), 4'b1110, 16);
        hold(pat(1), 4'b1101, 16);
        hold(pat(8), 4'b1011, 16);
        // Thousands capture lands 5 cycles in; 8 cycles puts us mid-conversion.
        hold(pat(0), 4'b0111, 8);
        reset = 1'b0;
        seg   = 7'h7F;
        an    = 4'hF;
        #1;
        checks++; if (digits !== 16'h0)    begin errors++; $display("FAIL midreset_digits: got %h expected %h", digits, 16'h0); end
        checks++; if (game_time !== 16'h0) begin errors++; $display("FAIL midreset_game_time: got %h expected %h", game_time, 16'h0); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_cycles(15);
        checks++; if (fv_cnt !== fv0)      begin errors++; $display("FAIL midreset_no_valid: got %0d expected 0", fv_cnt - fv0); end
        checks++; if (fe_cnt !== fe0)      begin errors++; $display("FAIL midreset_no_err: got %0d expected 0", fe_cnt - fe0); end
        checks++; if (game_time !== 16'h0) begin errors++; $display("FAIL midreset_game_time_held: got %h expected %h", game_time, 16'h0); end
        scan(pat(0), pat(8), pat(1), pat(5), 16, c_last);
        wait_cycles(12);
        checks++; if (fv_cnt !== fv0 + 1)     begin errors++; $display("FAIL after_reset_pulses: got %0d expected 1", fv_cnt - fv0); end
        checks++; if (game_time !== 16'd815)  begin errors++; $display("FAIL after_reset_game_time: got %0d expected %0d", game_time, 815); end
        checks++; if (digits !== 16'h0815)    begin errors++; $display("FAIL after_reset_digits: got %h expected %h", digits, 16'h0815); end
    endtask

    task automatic test_back_to_back;
        int c_last;
        int fv0;
        fv0 = fv_cnt;
        scan(pat(9), pat(9), pat(9), pat(9), 5, c_last);
        scan(pat(0), pat(0), pat(0), pat(0), 5, c_last);
        wait_cycles(12);
        checks++; if (fv_cnt !== fv0 + 2) begin errors++; $display("FAIL b2b_pulses: got %0d expected 2", fv_cnt - fv0); end
        checks++; if (gt_log[fv0[5:0]] !== 16'd9999) begin errors++; $display("FAIL b2b_first_value: got %0d expected %0d", gt_log[fv0[5:0]], 9999); end
        checks++; if (gt_log[6'(fv0 + 1)] !== 16'd0) begin errors++; $display("FAIL b2b_second_value: got %0d expected 0", gt_log[6'(fv0 + 1)]); end
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL b2b_digits: got %h expected %h", digits, 16'h0000); end
        checks++; if (fv_cyc !== c_last + 11) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", fv_cyc, c_last + 11); end
    endtask

    initial begin
        test_reset;
        test_scan_1234;
        test_blank;
        test_invalid;
        test_toggle_stale;
        test_reset_mid;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
